// File: rtl/backoff_timer.sv
// Truncated binary exponential backoff timer: draws a masked random slot count
// from a free-running XNOR LFSR, counts the slots, then pulses done.
module backoff_timer #(
   parameter int                    LFSR_WIDTH    = 10,
   parameter logic [LFSR_WIDTH-1:0] TAP_MASK      = 10'h204,
   parameter int                    BACKOFF_LIMIT = 10,
   parameter int                    SLOT_CYCLES   = 256,
   parameter int                    MAX_ATTEMPTS  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [4:0]            attempt,
   output logic                  busy,
   output logic                  trigger,
   output logic                  done,
   output logic                  excessive,
   output logic [LFSR_WIDTH-1:0] slots_left
);

   localparam int CNT_W = $clog2(SLOT_CYCLES);

   typedef enum logic {IDLE, COUNT} state_t;

   state_t                  state;
   logic [LFSR_WIDTH-1:0]   lfsr;
   logic [LFSR_WIDTH-1:0]   draw_mask;
   logic [LFSR_WIDTH-1:0]   draw;
   logic [CNT_W-1:0]        slot_cnt;
   logic [4:0]              mask_exp;
   logic                    too_many;

   // XNOR feedback makes all-zero a legal state, so reset to zero is safe.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lfsr <= '0;
      end else begin
         lfsr <= {lfsr[LFSR_WIDTH-2:0], ~^(lfsr & TAP_MASK)};
      end
   end

   always_comb begin
      too_many = (int'(attempt) >= MAX_ATTEMPTS);
      if (int'(attempt) > BACKOFF_LIMIT) begin
         mask_exp = 5'(BACKOFF_LIMIT);
      end else begin
         mask_exp = attempt;
      end
   end

   // Mask keeps the low min(attempt, BACKOFF_LIMIT) bits of the LFSR.
   genvar gi;
   generate
      for (gi = 0; gi < LFSR_WIDTH; gi++) begin : g_mask
         assign draw_mask[gi] = (int'(mask_exp) > gi);
      end
   endgenerate

   assign draw    = lfsr & draw_mask;
   assign trigger = ~busy;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         slot_cnt   <= '0;
         slots_left <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         excessive  <= 1'b0;
      end else begin
         done      <= 1'b0;
         excessive <= 1'b0;
         if (abort) begin
            state      <= IDLE;
            busy       <= 1'b0;
            slots_left <= '0;
            slot_cnt   <= '0;
         end else if (start) begin
            slot_cnt <= '0;
            if (too_many) begin
               // No draw: slots_left keeps whatever it held.
               state     <= IDLE;
               busy      <= 1'b0;
               excessive <= 1'b1;
            end else begin
               state      <= COUNT;
               busy       <= 1'b1;
               slots_left <= draw;
            end
         end else if (state == COUNT) begin
            if (slots_left == '0) begin
               state    <= IDLE;
               busy     <= 1'b0;
               done     <= 1'b1;
               slot_cnt <= '0;
            end else if (slot_cnt == CNT_W'(SLOT_CYCLES - 1)) begin
               slot_cnt   <= '0;
               slots_left <= slots_left - LFSR_WIDTH'(1);
            end else begin
               slot_cnt <= slot_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_backoff_timer.sv
// Randomised and directed bench for backoff_timer, checked every cycle against a
// timeline model: a backoff started at t is busy until t+1+r*S and completes at t+2+r*S.
module tb_backoff_timer;

   localparam int              W     = 10;
   localparam int              S     = 4;
   localparam int              LIMIT = 10;
   localparam int              MAXA  = 16;
   localparam logic [W-1:0]    TAPS  = 10'h204;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic [4:0]    attempt;
   logic          busy;
   logic          trigger;
   logic          done;
   logic          excessive;
   logic [W-1:0]  slots_left;

   backoff_timer #(
      .LFSR_WIDTH    (W),
      .TAP_MASK      (TAPS),
      .BACKOFF_LIMIT (LIMIT),
      .SLOT_CYCLES   (S),
      .MAX_ATTEMPTS  (MAXA)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .attempt    (attempt),
      .busy       (busy),
      .trigger    (trigger),
      .done       (done),
      .excessive  (excessive),
      .slots_left (slots_left)
   );

   always #5 clock = ~clock;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model state: the current backoff is described by its first busy cycle and its draw.
   int          cyc;
   logic [W-1:0] m_lfsr;
   bit          m_active;
   int          m_t1;
   int          m_r;
   int          m_hold;
   bit          e_done;
   bit          e_exc;

   function automatic logic [W-1:0] lfsr_next(logic [W-1:0] v);
      logic fb;
      fb = (($countones(v & TAPS) % 2) == 0);
      return {v[W-2:0], fb};
   endfunction

   function automatic int exp_slots(int c);
      if (m_active) return m_r - (c - m_t1) / S;
      return m_hold;
   endfunction

   task automatic model_reset();
      m_lfsr   = '0;
      m_active = 0;
      m_hold   = 0;
      m_t1     = 0;
      m_r      = 0;
      e_done   = 0;
      e_exc    = 0;
   endtask

   // Applies the inputs that were present at the edge just taken.
   task automatic model_update();
      int prev;
      int old_slots;
      int k;
      if (reset) return;
      prev      = cyc;
      cyc       = cyc + 1;
      old_slots = exp_slots(prev);
      e_done    = 0;
      e_exc     = 0;
      if (abort) begin
         m_active = 0;
         m_hold   = 0;
      end else if (start) begin
         if (int'(attempt) >= MAXA) begin
            e_exc    = 1;
            m_hold   = old_slots;
            m_active = 0;
         end else begin
            k        = (int'(attempt) < LIMIT) ? int'(attempt) : LIMIT;
            m_r      = int'(m_lfsr) % (1 << k);
            m_t1     = cyc;
            m_active = 1;
         end
      end else if (m_active && prev == m_t1 + m_r * S) begin
         e_done   = 1;
         m_active = 0;
         m_hold   = 0;
      end
      m_lfsr = lfsr_next(m_lfsr);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic compare_all();
      chk("busy",       32'(busy),       32'(m_active));
      chk("trigger",    32'(trigger),    32'(!m_active));
      chk("done",       32'(done),       32'(e_done));
      chk("excessive",  32'(excessive),  32'(e_exc));
      chk("slots_left", 32'(slots_left), 32'(exp_slots(cyc)));
   endtask

   task automatic cycle();
      @(posedge clock);
      #1;
      model_update();
      @(negedge clock);
      compare_all();
      $display("cyc %0d start=%0b abort=%0b att=%0d busy=%0b done=%0b exc=%0b slots=%0d",
               cyc, start, abort, attempt, busy, done, excessive, slots_left);
   endtask

   initial begin
      int n;
      int s2;
      logic [W-1:0] saved;
      reset   = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      attempt = '0;
      cyc     = 0;
      model_reset();
      repeat (2) cycle();
      chk("rst_busy",    32'(busy),       32'd0);
      chk("rst_trigger", 32'(trigger),    32'd1);
      chk("rst_done",    32'(done),       32'd0);
      chk("rst_exc",     32'(excessive),  32'd0);
      chk("rst_slots",   32'(slots_left), 32'd0);
      reset = 1'b0;

      // LFSR runs 0 -> 1 -> 3 -> 7, so a full-width draw here is 7.
      repeat (3) cycle();
      start = 1'b1; attempt = 5'd10;
      cycle();
      start = 1'b0;
      chk("lfsr_seq_draw", 32'(slots_left), 32'd7);
      chk("lfsr_seq_busy", 32'(busy),       32'd1);
      repeat (28) cycle();
      chk("seven_last_slots", 32'(slots_left), 32'd0);
      chk("seven_last_busy",  32'(busy),       32'd1);
      cycle();
      chk("seven_done", 32'(done), 32'd1);
      chk("seven_idle", 32'(busy), 32'd0);
      cycle();
      chk("seven_done_pulse", 32'(done), 32'd0);

      // Zero draw.
      start = 1'b1; attempt = 5'd0;
      cycle();
      start = 1'b0;
      chk("zero_busy",  32'(busy),       32'd1);
      chk("zero_slots", 32'(slots_left), 32'd0);
      chk("zero_nodone", 32'(done),      32'd0);
      cycle();
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_idle", 32'(busy), 32'd0);
      cycle();
      chk("zero_done_pulse", 32'(done), 32'd0);

      // Single-slot draw on an odd LFSR value.
      n = 0;
      while (m_lfsr[0] == 1'b0 && n < 64) begin
         cycle();
         n++;
      end
      if (m_lfsr[0] == 1'b0) begin
         n_cmp++; n_fail++;
         $display("FAIL wait_odd_lfsr: got even value %0d expected odd", m_lfsr);
      end
      start = 1'b1; attempt = 5'd1;
      cycle();
      start = 1'b0;
      chk("one_slot_t1", 32'(slots_left), 32'd1);
      repeat (4) cycle();
      chk("one_slot_t5", 32'(slots_left), 32'd0);
      chk("one_slot_busy5", 32'(busy),    32'd1);
      cycle();
      chk("one_slot_done", 32'(done), 32'd1);

      // Limit masking with attempt above BACKOFF_LIMIT, then abort.
      saved = m_lfsr;
      start = 1'b1; attempt = 5'd15;
      cycle();
      start = 1'b0;
      chk("limit_draw", 32'(slots_left), 32'(saved));
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      chk("abort_idle",   32'(busy),       32'd0);
      chk("abort_slots",  32'(slots_left), 32'd0);
      chk("abort_nodone", 32'(done),       32'd0);

      // Excessive attempt.
      start = 1'b1; attempt = 5'd16;
      cycle();
      start = 1'b0;
      chk("exc_pulse", 32'(excessive),  32'd1);
      chk("exc_busy",  32'(busy),       32'd0);
      chk("exc_slots", 32'(slots_left), 32'd0);
      cycle();
      chk("exc_pulse_end", 32'(excessive), 32'd0);

      // Start and abort together.
      start = 1'b1; abort = 1'b1; attempt = 5'd4;
      cycle();
      start = 1'b0; abort = 1'b0;
      chk("start_abort_idle", 32'(busy), 32'd0);

      // Restart while busy: completion is timed from the second start.
      start = 1'b1; attempt = 5'd6;
      cycle();
      start = 1'b0;
      repeat (2) cycle();
      s2 = int'(m_lfsr) % 4;
      start = 1'b1; attempt = 5'd2;
      cycle();
      start = 1'b0;
      chk("restart_draw", 32'(slots_left), 32'(s2));
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         cycle();
         n++;
      end
      chk("restart_latency", 32'(n), 32'(1 + s2 * S));

      // attempt=3 never yields more than 7 slots.
      for (int i = 0; i < 1000; i++) begin
         start = 1'b1; attempt = 5'd3;
         cycle();
         chk("mask3_bound", 32'(slots_left <= W'(7)), 32'd1);
      end
      start = 1'b0; abort = 1'b1;
      cycle();
      abort = 1'b0;

      // Random traffic with one asynchronous reset mid-run.
      for (int i = 0; i < 4000; i++) begin
         int sel;
         if (i == 2000) begin
            start = 1'b0; abort = 1'b0;
            reset = 1'b1;
            model_reset();
            #1;
            compare_all();
            repeat (2) cycle();
            reset = 1'b0;
         end
         sel   = $urandom_range(0, 99);
         start = ($urandom_range(0, 19) == 0);
         abort = ($urandom_range(0, 59) == 0);
         if (sel < 80)      attempt = 5'($urandom_range(0, 5));
         else if (sel < 95) attempt = 5'($urandom_range(6, 17));
         else               attempt = 5'($urandom_range(18, 31));
         cycle();
      end

      start = 1'b0; abort = 1'b1;
      cycle();
      abort = 1'b0;
      cycle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
